serial_sub_nb: RTL and testbench

- Bit-serial N-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first, with a single borrow flip-flop.
- Reports the per-bit borrow vector, the same shape as the per-bit carry vector of the lab full-adder blocks.
- Sits beside the combinational adders in the lab datapath as their sequential inverse operation. Uses a start/busy/done handshake for a controller or bench.

---
 rtl/serial_sub_nb.sv | 116 +++++++++++
 tb/tb_serial_sub_nb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_sub_nb.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock, with per-bit borrow vector.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_nb #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_nxt;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign d      = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are written bit-by-bit in place; earlier bits hold until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr      <= a_sr >> 1;
            b_sr      <= b_sr >> 1;
            br        <= br_nxt;
            diff[cnt] <= d;
            bout[cnt] <= br_nxt;
            cnt       <= cnt + 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            if (last) begin
                ovf <= br_nxt ^ bout[WIDTH-2];
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_sub_nb.sv
// Directed-vector bench for serial_sub_nb (WIDTH=3); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_nb;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic [W-1:0] bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic armed     = 1'b0;
    logic prev_done = 1'b0;

    serial_sub_nb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("no_xz", 32'($isunknown({busy, done, diff, bout})), 32'd0);
            check("done_twice", 32'(prev_done & done), 32'd0);
            prev_done = done;
        end
    end

    task automatic check_result(input string tag, input logic [W-1:0] ed, input logic [W-1:0] eb,
                                input logic eovf);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unused");
`endif
    endtask

    // Accept at E0, scramble inputs afterwards, expect done exactly after E0+W.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic bi_in, input logic [W-1:0] ed, input logic [W-1:0] eb,
                          input logic eovf);
        a = ai; b = bi; bin = bi_in; start = 1'b1;
        tick();
        check({tag, "_acc"}, 32'({busy, done}), 32'b10);
        start = 1'b0; a = ~ai; b = ~bi; bin = ~bi_in;
        for (int i = 0; i < int'(W) - 1; i++) begin
            tick();
            check({tag, "_shift"}, 32'({busy, done}), 32'b10);
        end
        tick();
        check_result(tag, ed, eb, eovf);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        check("rst_state", 32'({busy, done, diff, bout}), 32'd0);
        rst = 1'b0;
        armed = 1'b1;

        run_op("sub_5_3", 3'd5, 3'd3, 1'b0, 3'd2, 3'b010, 1'b1);
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_hold", 32'({diff, bout}), 32'({3'd2, 3'b010}));

        run_op("wrap_2_3", 3'd2, 3'd3, 1'b0, 3'd7, 3'b111, 1'b0);
        tick();
        run_op("bin_0_0", 3'd0, 3'd0, 1'b1, 3'd7, 3'b111, 1'b0);
        tick();
        run_op("ovf_3_4", 3'b011, 3'b100, 1'b0, 3'd7, 3'b100, 1'b1);
        tick();

        // start held through SHIFT, then back-to-back accept in the DONE cycle
        a = 3'd6; b = 3'd1; bin = 1'b0; start = 1'b1;
        tick();
        check("hold_acc", 32'({busy, done}), 32'b10);
        tick();
        check("hold_s1", 32'({busy, done}), 32'b10);
        tick();
        check("hold_s2", 32'({busy, done}), 32'b10);
        tick();
        check_result("hold_6_1", 3'd5, 3'b001, 1'b0);
        a = 3'd7; b = 3'd7; bin = 1'b1;
        tick();
        check("b2b_acc", 32'({busy, done}), 32'b10);
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        tick();
        check_result("b2b_7_7", 3'd7, 3'b111, 1'b0);
        tick();
        check("b2b_idle", 32'(done), 32'd0);

        // reset during the second SHIFT cycle aborts the operation
        a = 3'd5; b = 3'd3; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; a = 3'd0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_out", 32'({busy, done, diff, bout}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_nodone", 32'({busy, done}), 32'd0);
        end
        run_op("eq_1_1", 3'd1, 3'd1, 1'b0, 3'd0, 3'b000, 1'b0);
        tick();
        tick();

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
